// File: rtl/bus_ctrl_pkg.sv
// Shared types and helpers for the internal-bus transfer sequencer.
package bus_ctrl_pkg;

  localparam int unsigned DEF_NREG = 4;
  localparam int unsigned DEF_NREQ = 2;
  localparam int unsigned MAX_NREG = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EN_SRC    = 2'd1,
    LATCH_DST = 2'd2,
    EN_DST    = 2'd3
  } xfer_state_t;

  // Indices at or beyond n decode to an all-zero vector, so bad indices become no-ops.
  function automatic logic [MAX_NREG-1:0] idx_onehot(input int unsigned idx,
                                                     input int unsigned n);
    logic [MAX_NREG-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < MAX_NREG; i++) begin
      oh[i] = (i == idx) && (i < n);
    end
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter; search starts one past the last accepted requester.
module rr_arbiter #(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW-1:0] last_q;
  logic [IDW-1:0] last_d;
  logic [IDW-1:0] idx_c;
  logic           found_c;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx_c     = '0;
    found_c   = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx_c = IDW'((32'(last_q) + k) % NREQ);
      if (!found_c && req[idx_c]) begin
        found_c        = 1'b1;
        grant[idx_c]   = 1'b1;
        grant_idx      = idx_c;
      end
    end
  end

  assign last_d = advance ? grant_idx : last_q;

  // Reset to the top index so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= IDW'(NREQ - 1);
    else        last_q <= last_d;
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Bus transfer sequencer: arbitrates requests and walks publish-src, capture-dst,
// publish-dst with registered strobes.
module bus_xfer_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter  int unsigned NREG = DEF_NREG,
  parameter  int unsigned NREQ = DEF_NREQ,
  localparam int unsigned IW   = (NREG > 1) ? $clog2(NREG) : 1,
  localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*IW-1:0] req_src,
  input  logic [NREQ*IW-1:0] req_dst,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREG-1:0]    latch_o,
  output logic [NREG-1:0]    en_o,
  output logic [IW-1:0]      bus_sel,
  output logic               busy,
  output logic               done,
  output logic [IDW-1:0]     done_id
);

  xfer_state_t     state_q, state_d;
  logic [IW-1:0]   src_q, src_d, dst_q, dst_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [NREG-1:0] latch_d, en_d;
  logic [IW-1:0]   sel_d;
  logic            busy_d, done_d;
  logic [IDW-1:0]  done_id_d;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            idle_c, accept_c;

  // Readiness is masked during reset so nothing is accepted while rst_n is low.
  assign idle_c    = rst_n && (state_q == IDLE);
  assign accept_c  = idle_c && (|req_valid);
  assign req_ready = idle_c ? grant : '0;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .advance   (accept_c),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Strobes are decoded from the next state so they register in step with it.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    id_d      = id_q;
    latch_d   = '0;
    en_d      = '0;
    sel_d     = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    done_id_d = '0;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
              src_d = req_src[i*IW +: IW];
              dst_d = req_dst[i*IW +: IW];
            end
          end
          id_d    = grant_idx;
          state_d = EN_SRC;
        end
      end
      EN_SRC:    state_d = (src_q == dst_q) ? EN_DST : LATCH_DST;
      LATCH_DST: state_d = EN_DST;
      EN_DST:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    unique case (state_d)
      EN_SRC: begin
        en_d  = NREG'(idx_onehot(32'(src_d), NREG));
        sel_d = src_d;
      end
      LATCH_DST: begin
        latch_d = NREG'(idx_onehot(32'(dst_d), NREG));
        sel_d   = src_d;
      end
      EN_DST: begin
        en_d      = NREG'(idx_onehot(32'(dst_d), NREG));
        sel_d     = dst_d;
        done_d    = 1'b1;
        done_id_d = id_d;
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      id_q    <= '0;
      latch_o <= '0;
      en_o    <= '0;
      bus_sel <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      id_q    <= id_d;
      latch_o <= latch_d;
      en_o    <= en_d;
      bus_sel <= sel_d;
      busy    <= busy_d;
      done    <= done_d;
      done_id <= done_id_d;
    end
  end

endmodule
